// File: rtl/reduce_pkg.sv
// Shared types and constants for the reduction pipeline.
package reduce_pkg;

  localparam int unsigned MIN_WIDTH = 2;
  localparam int unsigned MAX_WIDTH = 64;

  typedef enum logic [1:0] {
    OP_AND  = 2'd0,
    OP_OR   = 2'd1,
    OP_XOR  = 2'd2,
    OP_XNOR = 2'd3
  } op_e;

  // XNOR travels through the tree as XOR; inversion happens only at the root.
  function automatic logic reduce2(op_e op, logic a, logic b);
    case (op)
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      default: return a ^ b;
    endcase
  endfunction

endpackage

// File: rtl/reduce_stage.sv
// One tree level: N operand bits in, N/2 registered partial results out,
// with valid and op carried alongside; holds when en is low.
module reduce_stage
  import reduce_pkg::*;
#(
  parameter int unsigned N    = 2,
  parameter bit          LAST = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             in_valid,
  input  logic [1:0]       in_op,
  input  logic [N-1:0]     in_bits,
  output logic             out_valid,
  output logic [1:0]       out_op,
  output logic [N/2-1:0]   out_bits
);

  localparam int unsigned HALF = N / 2;

  logic            valid_q, valid_d;
  logic [1:0]      op_q, op_d;
  logic [HALF-1:0] bits_q, bits_d;

  always_comb begin
    valid_d = valid_q;
    op_d    = op_q;
    bits_d  = bits_q;
    if (en) begin
      valid_d = in_valid;
      op_d    = in_op;
      for (int i = 0; i < int'(HALF); i++) begin
        bits_d[i] = reduce2(op_e'(in_op), in_bits[2*i], in_bits[2*i+1]);
      end
      if (LAST && (op_e'(in_op) == OP_XNOR)) begin
        bits_d = ~bits_d;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      op_q    <= 2'b00;
      bits_q  <= '0;
    end else begin
      valid_q <= valid_d;
      op_q    <= op_d;
      bits_q  <= bits_d;
    end
  end

  assign out_valid = valid_q;
  assign out_op    = op_q;
  assign out_bits  = bits_q;

endmodule

// File: rtl/reduce_pipe.sv
// Pipelined AND/OR/XOR/XNOR reduction tree with valid/ready handshake.
// Optional REDUCE_PIPE_STATS_EN adds a saturating output-transfer counter (done_cnt).
module reduce_pipe
  import reduce_pkg::*;
#(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned LEVELS = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [1:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_y,
  output logic [1:0]       out_op
`ifdef REDUCE_PIPE_STATS_EN
  ,
  output logic [15:0]      done_cnt
`endif
);

  localparam int unsigned TREE_BITS = 2 * WIDTH - 1;

  // Level l of the tree occupies WIDTH>>l bits starting at 2*WIDTH - 2*(WIDTH>>l).
  logic [TREE_BITS-1:0]  tree;
  logic [LEVELS:0]       vld;
  logic [LEVELS:0][1:0]  ops;
  logic                  advance;

  assign advance           = !out_valid || out_ready;
  assign in_ready          = advance;
  assign tree[WIDTH-1:0]   = in_a;
  assign vld[0]            = in_valid;
  assign ops[0]            = in_op;

  for (genvar l = 0; l < int'(LEVELS); l++) begin : g_lvl
    localparam int unsigned N     = WIDTH >> l;
    localparam int unsigned OFF_I = 2 * WIDTH - 2 * N;
    localparam int unsigned OFF_O = 2 * WIDTH - N;

    reduce_stage #(
      .N    (N),
      .LAST (l == int'(LEVELS) - 1)
    ) u_stage (
      .clk       (clk),
      .reset     (reset),
      .en        (advance),
      .in_valid  (vld[l]),
      .in_op     (ops[l]),
      .in_bits   (tree[OFF_I +: N]),
      .out_valid (vld[l+1]),
      .out_op    (ops[l+1]),
      .out_bits  (tree[OFF_O +: N/2])
    );
  end

  assign out_valid = vld[LEVELS];
  assign out_op    = ops[LEVELS];
  assign out_y     = tree[TREE_BITS-1];

`ifdef REDUCE_PIPE_STATS_EN
  logic [15:0] done_cnt_q, done_cnt_d;

  always_comb begin
    done_cnt_d = done_cnt_q;
    if (out_valid && out_ready && (done_cnt_q != 16'hFFFF)) begin
      done_cnt_d = done_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      done_cnt_q <= 16'd0;
    end else begin
      done_cnt_q <= done_cnt_d;
    end
  end

  assign done_cnt = done_cnt_q;
`endif

endmodule

// File: tb/tb_reduce_pipe.sv
// Self-checking bench for reduce_pipe (WIDTH=8): vector table, stall, reset
// and randomized traffic against an in-order scoreboard.
module tb_reduce_pipe;

  typedef struct {
    logic [7:0] a;
    logic [1:0] op;
    logic       y;
  } vec_t;

  typedef struct {
    logic       y;
    logic [1:0] op;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_a = 8'h00;
  logic [1:0] in_op = 2'd0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic       out_y;
  logic [1:0] out_op;
`ifdef REDUCE_PIPE_STATS_EN
  logic [15:0] done_cnt;
`endif

  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_push = 0;
  exp_t sb[$];

  reduce_pipe #(.WIDTH(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_op     (in_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_y     (out_y),
    .out_op    (out_op)
`ifdef REDUCE_PIPE_STATS_EN
    ,
    .done_cnt  (done_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic model(logic [7:0] a, logic [1:0] op);
    case (op)
      2'd0:    return &a;
      2'd1:    return |a;
      2'd2:    return ^a;
      default: return ~^a;
    endcase
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // One clock: drive at edge+1, record expectation if the transfer will happen.
  task automatic cycle(logic v, logic [7:0] a, logic [1:0] op, logic rdy, logic exp_y);
    in_valid  = v;
    in_a      = a;
    in_op     = op;
    out_ready = rdy;
    #1;
    if (v && in_ready && !reset) begin
      sb.push_back('{y: exp_y, op: op});
      n_push++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    in_valid = 1'b0;
    sb.delete();
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic drain(string name);
    for (int i = 0; i < 50 && sb.size() > 0; i++) cycle(1'b0, 8'h00, 2'd0, 1'b1, 1'b0);
    check(name, 32'(sb.size()), 32'd0);
  endtask

  // Output side of the scoreboard: pop and compare on every output transfer.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_out: actual y=%0d op=%0d, required no output", out_y, out_op);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("out_y", 32'(out_y), 32'(e.y));
        check("out_op", 32'(out_op), 32'(e.op));
      end
    end
  end

  initial begin
    vec_t tbl[12];
    int   lat;
    logic [7:0] ra;
    logic [1:0] rop;

    tbl[0]  = '{a: 8'hFF, op: 2'd0, y: 1'b1};
    tbl[1]  = '{a: 8'hFE, op: 2'd0, y: 1'b0};
    tbl[2]  = '{a: 8'h01, op: 2'd2, y: 1'b1};
    tbl[3]  = '{a: 8'h03, op: 2'd2, y: 1'b0};
    tbl[4]  = '{a: 8'h00, op: 2'd1, y: 1'b0};
    tbl[5]  = '{a: 8'h07, op: 2'd3, y: 1'b0};
    tbl[6]  = '{a: 8'h80, op: 2'd1, y: 1'b1};
    tbl[7]  = '{a: 8'h00, op: 2'd3, y: 1'b1};
    tbl[8]  = '{a: 8'h55, op: 2'd2, y: 1'b0};
    tbl[9]  = '{a: 8'h54, op: 2'd3, y: 1'b0};
    tbl[10] = '{a: 8'h7F, op: 2'd0, y: 1'b0};
    tbl[11] = '{a: 8'hFF, op: 2'd3, y: 1'b1};

    // Reset state
    do_reset();
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_y", 32'(out_y), 32'd0);
    check("rst_out_op", 32'(out_op), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);

    // Latency of a single vector with the consumer always ready
    cycle(1'b1, 8'hFF, 2'd0, 1'b1, 1'b1);
    lat = 1;
    while (!out_valid && lat < 10) begin
      cycle(1'b0, 8'h00, 2'd0, 1'b1, 1'b0);
      lat++;
    end
    check("latency", 32'(lat), 32'd3);
    drain("drain_latency");

    // Back-to-back table vectors
    foreach (tbl[i]) cycle(1'b1, tbl[i].a, tbl[i].op, 1'b1, tbl[i].y);
    drain("drain_table");

    // Fill the pipe with the consumer stalled, hold, then release
    for (int i = 0; i < 4; i++) begin
      ra  = 8'($urandom);
      rop = 2'($urandom);
      cycle(1'b1, ra, rop, 1'b0, model(ra, rop));
    end
    check("stall_fill", 32'(sb.size()), 32'd3);
    for (int i = 0; i < 5; i++) begin
      ra  = 8'($urandom);
      rop = 2'($urandom);
      cycle(1'b1, ra, rop, 1'b0, model(ra, rop));
      check("stall_in_ready", 32'(in_ready), 32'd0);
      check("stall_out_valid", 32'(out_valid), 32'd1);
      check("stall_out_y", 32'(out_y), 32'(sb[0].y));
      check("stall_out_op", 32'(out_op), 32'(sb[0].op));
    end
    drain("drain_stall");

    // Reset with three items in flight: nothing may emerge afterward
    for (int i = 0; i < 3; i++) cycle(1'b1, 8'hFF, 2'd1, 1'b1, 1'b1);
    reset    = 1'b1;
    in_valid = 1'b0;
    sb.delete();
    @(posedge clk);
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      cycle(1'b0, 8'h00, 2'd0, 1'b1, 1'b0);
      check("midrst_quiet", 32'(out_valid), 32'd0);
    end

    // Randomized valid/ready traffic over all ops
    begin
      int target;
      int budget;
      target = n_push + 2000;
      budget = 0;
      while (n_push < target && budget < 20000) begin
        ra  = 8'($urandom);
        rop = 2'($urandom);
        cycle(1'($urandom), ra, rop, 1'($urandom), model(ra, rop));
        budget++;
      end
      check("random_accepted", 32'(n_push >= target), 32'd1);
    end
    drain("drain_random");

`ifdef REDUCE_PIPE_STATS_EN
    do_reset();
    check("cnt_reset", 32'(done_cnt), 32'd0);
    for (int i = 0; i < 70000; i++) cycle(1'b1, 8'hFF, 2'd0, 1'b1, 1'b1);
    drain("drain_stats");
    check("cnt_saturate", 32'(done_cnt), 32'h0000FFFF);
    do_reset();
    check("cnt_cleared", 32'(done_cnt), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
